// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the three handshakes around the fetch front end:
//   imem_*            : one-outstanding-request instruction memory port
//   flush / flush_pc  : redirect from the back end
//   deq / valid / pc / instruction : head-of-queue port to the decoder
// Modports:
//   master : the fetch queue (drives the memory request and the decoder view)
//   slave  : the environment (memory, back end and decoder)
// ----------------------------------------------------------------------------
interface fetch_queue_if;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        flush;
    logic [31:0] flush_pc;
    logic        deq;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;

    modport master (
        output imem_address, imem_read, valid, instruction, pc,
        input  imem_rdata, imem_resp, flush, flush_pc, deq
    );

    modport slave (
        input  imem_address, imem_read, valid, instruction, pc,
        output imem_rdata, imem_resp, flush, flush_pc, deq
    );
endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end. Keeps the fetch PC, issues one memory request
// at a time, and buffers returned {pc, instruction} pairs in a circular queue
// read by the decoder. A flush empties the queue and restarts fetch; a
// response still in flight at flush time is waited out and dropped.
// Parameters:
//   DEPTH    : queue entries (power of two, >= 2)
//   RESET_PC : first fetch address after reset
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : fetch_queue_if.master (memory port, redirect, decoder head port)
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,  // request outstanding, a queue slot is reserved
        ST_STALL   = 2'd1,  // queue full, no request
        ST_DISCARD = 2'd2   // waiting out a response from before a flush
    } state_t;

    state_t        r_state;
    logic          r_imem_read;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_redirect_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic [31:0]   r_q_pc    [DEPTH];
    logic [31:0]   r_q_instr [DEPTH];

    logic          w_valid;
    logic          w_deq;
    logic          w_enq;
    logic [AW:0]   w_count_next;

    assign w_valid = (r_count != '0);
    assign w_deq   = bus.deq && w_valid;
    // Only a response in FETCH carries a new-path instruction.
    assign w_enq   = (r_state == ST_FETCH) && bus.imem_resp;

    // Occupancy after this cycle's dequeue/enqueue, ignoring flush.
    always_comb begin
        // NOTE: default assignment first so no path leaves the value held (no latch).
        w_count_next = r_count;
        if (w_enq && !w_deq) begin
            w_count_next = r_count + ONE;
        end else if (!w_enq && w_deq) begin
            w_count_next = r_count - ONE;
        end
    end

    // NOTE: the entry storage has no reset; r_count decides which slots are
    // live, so an unwritten slot is never presented as valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_pc[r_tail]    <= r_fetch_pc;
            r_q_instr[r_tail] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_FETCH;
            r_imem_read   <= 1'b1;
            r_fetch_pc    <= RESET_PC;
            r_redirect_pc <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else if (bus.flush) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_imem_read <= 1'b1;
            // A request is still in flight when the FSM is issuing one and
            // no response arrives this cycle; keep the old address until it
            // returns and remember where to go afterwards.
            if (r_state != ST_STALL && !bus.imem_resp) begin
                r_state       <= ST_DISCARD;
                r_redirect_pc <= bus.flush_pc;
            end else begin
                r_state    <= ST_FETCH;
                r_fetch_pc <= bus.flush_pc;
            end
        end else begin
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            r_count <= w_count_next;

            case (r_state)
                ST_FETCH: begin
                    if (bus.imem_resp) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        // The next request needs a free slot to be reserved.
                        if (w_count_next == FULL) begin
                            r_state     <= ST_STALL;
                            r_imem_read <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    if (w_count_next != FULL) begin
                        r_state     <= ST_FETCH;
                        r_imem_read <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (bus.imem_resp) begin
                        r_fetch_pc <= r_redirect_pc;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state     <= ST_FETCH;
                    r_imem_read <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imem_address = r_fetch_pc;
    assign bus.imem_read    = r_imem_read;
    assign bus.valid        = w_valid;
    assign bus.pc           = r_q_pc[r_head];
    assign bus.instruction  = r_q_instr[r_head];

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that sits directly upstream of the instruction decoder. Holds the fetch PC, issues one request at a time to the instruction memory port, and buffers returned {pc, instruction} pairs in a circular queue. The decoder reads the queue head and pops it. A redirect from the back end flushes the queue and restarts fetch at a new PC, and any in-flight memory response is discarded correctly.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- RESET_PC, 32'h00000060, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- imem_address  out  32  fetch address; equals fetch_pc
- imem_read  out  1  fetch request; held high until imem_resp
- imem_rdata  in  32  instruction word; valid when imem_resp=1
- imem_resp  in  1  single-cycle response strobe for the outstanding request
- flush  in  1  redirect strobe from the back end
- flush_pc  in  32  redirect target; sampled when flush=1
- deq  in  1  decoder consumes the head entry
- valid  out  1  queue non-empty
- instruction  out  32  head entry instruction
- pc  out  32  head entry PC

## Operation
- Storage: DEPTH entries of {pc[31:0], instr[31:0]}, head/tail pointers of log2(DEPTH) bits with natural wrap, and count of log2(DEPTH)+1 bits. valid = (count != 0). instruction and pc come combinationally from the head entry and are don't-care when valid=0.
- FSM states:
  - FETCH: imem_read=1.
  - STALL: imem_read=0.
  - DISCARD: imem_read=1 at the stale address.
- FETCH, imem_resp=1, flush=0: enqueue {fetch_pc, imem_rdata}, then fetch_pc += 4 (mod 2^32). Stay in FETCH if count_next < DEPTH, else go to STALL.
- FETCH, imem_resp=0: hold imem_address/imem_read stable.
- STALL: go to FETCH when count_next < DEPTH. count_next is count after this cycle's deq.
- Flush, highest priority:
  - Queue is emptied (head=tail=0, count=0). deq and any enqueue in the same cycle are ignored.
  - If the state is FETCH with imem_resp=0, the request is in flight. Go to DISCARD: keep imem_address at the old fetch_pc and latch flush_pc into redirect_pc.
  - Otherwise (FETCH with imem_resp=1, STALL, or DISCARD with imem_resp=1): fetch_pc ← flush_pc and go to FETCH. The response is dropped.
- DISCARD, imem_resp=1, flush=0: drop the data, fetch_pc ← redirect_pc, go to FETCH.
- DISCARD, flush=1, imem_resp=0: redirect_pc ← new flush_pc, stay in DISCARD.
- deq while valid=0 is ignored. Enqueue and dequeue in the same cycle leave count unchanged.
- The queue never overflows. FETCH is only entered or held when a slot is guaranteed.

## Timing
- Reset: rst=0 at an edge sets head=tail=count=0, fetch_pc=RESET_PC, state=FETCH.
- Outputs in the first cycle after reset: valid=0, imem_read=1, imem_address=RESET_PC.
- Latency: imem_resp in cycle N makes the entry visible (valid=1, pc, instruction) in cycle N+1. imem_address advances by 4 in cycle N+1.
- With a 1-cycle-response memory and the decoder popping every cycle, throughput is 1 instruction/cycle.
- Full: the response that fills the last slot moves the FSM to STALL in the next cycle. A deq in any STALL cycle gives imem_read=1 in the following cycle.
- Flush in cycle N: valid=0 in cycle N+1.
  - Without an in-flight request, imem_address=flush_pc in cycle N+1.
  - With one in flight, the first new-path request appears in the cycle after the stale imem_resp.
- Reset mid-operation overrides everything, including DISCARD. An outstanding memory response after reset is not tracked; the memory must also be reset.

## Test plan
- Reset, then 1-cycle memory returning addr^32'hA5A5_0000; pop every cycle -> pc sequence 0x60, 0x64, 0x68…, each instruction matching, valid continuously high from cycle 2.
- No deq, 1-cycle memory, DEPTH=8 -> exactly 8 entries (pc 0x60–0x7C), then imem_read=0. One deq -> imem_read=1 next cycle at 0x80, count returns to 8.
- Flush with flush_pc=0x200 while in STALL with 8 entries -> next cycle valid=0, imem_address=0x200, first dequeued pc=0x200.
- 3-cycle memory, flush to 0x400 one cycle after request issue -> imem_address stays at the old PC until resp, stale data never enqueued, next request at 0x400.
- Second flush to 0x500 during DISCARD, then resp -> fetch resumes at 0x500, not 0x400.
- Flush coincident with imem_resp and deq with 3 entries queued -> queue empty next cycle, response dropped, fetch at flush_pc. Also: deq with valid=0 leaves count at 0.
